// File: rtl/cpu_pkg.sv
// Shared sequencer/decoder constants: PC width default, phase encoding, decode-address layout.
// The decoder indexes its lookup table with the same field offsets.
package cpu_pkg;

  localparam int PC_W_DEFAULT = 12;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  localparam int DA_W         = 7;
  localparam int DA_INSTR_MSB = 6;
  localparam int DA_INSTR_LSB = 3;
  localparam int DA_C_BIT     = 2;
  localparam int DA_Z_BIT     = 1;
  localparam int DA_PH_BIT    = 0;

endpackage

// File: rtl/program_counter.sv
// Program counter: modulo-2^W increment or load, load wins; one-cycle update.
// No backpressure; i_inc/i_load are already qualified by the caller.
import cpu_pkg::*;

module program_counter #(
  parameter int W = PC_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_addr,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: PC, fetch register, C/Z flags, phase; decode_addr is combinational from registers.
// Stalls on enable=0 or halted; optional breakpoint halt under `BREAKPOINT_EN.
import cpu_pkg::*;

module fetch_sequencer #(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [7:0]      prog_byte,
  input  logic            pc_inc,
  input  logic            pc_load,
  input  logic [PC_W-1:0] load_addr,
  input  logic            flag_we,
  input  logic            c_in,
  input  logic            z_in,
`ifdef BREAKPOINT_EN
  input  logic [PC_W-1:0] bp_addr,
  input  logic            bp_resume,
`endif
  output logic [PC_W-1:0] pc,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic            c_flag,
  output logic            z_flag,
  output logic            phase,
  output logic [DA_W-1:0] decode_addr,
  output logic            halted
);

  phase_e          r_phase;
  logic [3:0]      r_instr;
  logic [3:0]      r_oprnd;
  logic            r_c;
  logic            r_z;
  logic            w_run;
  logic            w_fetch;
  logic [PC_W-1:0] w_pc;

`ifdef BREAKPOINT_EN
  logic r_halted;
  assign w_run  = enable && !r_halted;
  assign halted = r_halted;

  // Resume only clears the halt; the pending EXEC edge happens on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_halted <= 1'b0;
    end else if (enable) begin
      if (r_halted) begin
        if (bp_resume) r_halted <= 1'b0;
      end else if (r_phase == PH_FETCH && w_pc == bp_addr) begin
        r_halted <= 1'b1;
      end
    end
  end
`else
  assign w_run  = enable;
  assign halted = 1'b0;
`endif

  assign w_fetch = (r_phase == PH_FETCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PH_FETCH;
      r_instr <= 4'h0;
      r_oprnd <= 4'h0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else if (w_run) begin
      case (r_phase)
        PH_FETCH: begin
          r_instr <= prog_byte[7:4];
          r_oprnd <= prog_byte[3:0];
          r_phase <= PH_EXEC;
        end
        default: begin
          if (flag_we) begin
            r_c <= c_in;
            r_z <= z_in;
          end
          r_phase <= PH_FETCH;
        end
      endcase
    end
  end

  program_counter #(.W(PC_W)) u_pc (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_inc       (w_run && (w_fetch || pc_inc)),
    .i_load      (w_run && !w_fetch && pc_load),
    .i_load_addr (load_addr),
    .o_pc        (w_pc)
  );

  assign pc     = w_pc;
  assign instr  = r_instr;
  assign oprnd  = r_oprnd;
  assign c_flag = r_c;
  assign z_flag = r_z;
  assign phase  = r_phase;

  always_comb begin
    decode_addr = '0;
    decode_addr[DA_INSTR_MSB:DA_INSTR_LSB] = r_instr;
    decode_addr[DA_C_BIT]  = r_c;
    decode_addr[DA_Z_BIT]  = r_z;
    decode_addr[DA_PH_BIT] = r_phase;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: driver predicts each edge's outcome from a behavioural model,
// monitor compares DUT state one step after every rising edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  prog_byte = 8'h00;
  logic        pc_inc = 1'b0;
  logic        pc_load = 1'b0;
  logic [11:0] load_addr = 12'h000;
  logic        flag_we = 1'b0;
  logic        c_in = 1'b0;
  logic        z_in = 1'b0;
  logic [11:0] bp_addr = 12'h000;
  logic        bp_resume = 1'b0;
  logic [11:0] pc;
  logic [3:0]  instr, oprnd;
  logic        c_flag, z_flag, phase, halted;
  logic [6:0]  decode_addr;

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .prog_byte(prog_byte),
    .pc_inc(pc_inc), .pc_load(pc_load), .load_addr(load_addr), .flag_we(flag_we),
    .c_in(c_in), .z_in(z_in),
`ifdef BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_resume(bp_resume),
`endif
    .pc(pc), .instr(instr), .oprnd(oprnd), .c_flag(c_flag), .z_flag(z_flag),
    .phase(phase), .decode_addr(decode_addr), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc; int instr; int oprnd; int c; int z; int ph; int halt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   drv_done = 0;

  // Behavioural model of the architectural state
  int m_pc = 0, m_instr = 0, m_oprnd = 0, m_c = 0, m_z = 0, m_ph = 0, m_halt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int da_of(input exp_t e);
    return e.instr * 8 + e.c * 4 + e.z * 2 + e.ph;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".pc"},     pc,          e.pc);
    check({tag, ".instr"},  instr,       e.instr);
    check({tag, ".oprnd"},  oprnd,       e.oprnd);
    check({tag, ".c"},      c_flag,      e.c);
    check({tag, ".z"},      z_flag,      e.z);
    check({tag, ".phase"},  phase,       e.ph);
    check({tag, ".halted"}, halted,      e.halt);
    check({tag, ".daddr"},  decode_addr, da_of(e));
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.oprnd = m_oprnd;
    e.c = m_c; e.z = m_z; e.ph = m_ph; e.halt = m_halt;
    return e;
  endfunction

  // One clock: drive at negedge, predict the next rising edge, queue the prediction.
  task automatic step(input bit rst, input bit en, input logic [7:0] pb, input bit inc,
                      input bit ld, input logic [11:0] la, input bit fwe,
                      input bit c, input bit z, input bit resume);
    exp_t zero;
    @(negedge clk);
    reset_n = rst; enable = en; prog_byte = pb; pc_inc = inc; pc_load = ld;
    load_addr = la; flag_we = fwe; c_in = c; z_in = z; bp_resume = resume;
    if (!rst) begin
      m_pc = 0; m_instr = 0; m_oprnd = 0; m_c = 0; m_z = 0; m_ph = 0; m_halt = 0;
      zero = snap();
      #1 compare_all("async_clr", zero);
    end else if (en) begin
      if (m_halt == 1) begin
        if (resume) m_halt = 0;
      end else if (m_ph == 0) begin
        m_instr = int'(pb) / 16;
        m_oprnd = int'(pb) % 16;
`ifdef BREAKPOINT_EN
        if (m_pc == int'(bp_addr)) m_halt = 1;
`endif
        m_pc = (m_pc + 1) % 4096;
        m_ph = 1;
      end else begin
        if (ld) m_pc = int'(la);
        else if (inc) m_pc = (m_pc + 1) % 4096;
        if (fwe) begin m_c = c; m_z = z; end
        m_ph = 0;
      end
    end
    q.push_back(snap());
  endtask

  task automatic idle(input bit en);
    step(1, en, 8'h00, 0, 0, 12'h000, 0, 0, 0, 0);
  endtask

  initial begin : driver
    repeat (2) step(0, 0, 8'h00, 0, 0, 12'h000, 0, 0, 0, 0);
    // first fetch after reset, then EXEC with both load and inc
    step(1, 1, 8'h4A, 1, 1, 12'h3F0, 1, 1, 1, 0);
    step(1, 1, 8'hFF, 1, 1, 12'h3F0, 0, 0, 0, 0);
    // flag write, then a non-writing EXEC with different ALU results
    step(1, 1, 8'h73, 0, 0, 12'h000, 0, 0, 0, 0);
    step(1, 1, 8'h00, 0, 0, 12'h000, 1, 1, 0, 0);
    step(1, 1, 8'h21, 0, 0, 12'h000, 0, 0, 0, 0);
    step(1, 1, 8'h00, 1, 0, 12'h000, 0, 0, 1, 0);
    // load FFF, fetch wraps to 000
    step(1, 1, 8'h5C, 0, 0, 12'h000, 0, 0, 0, 0);
    step(1, 1, 8'h00, 0, 1, 12'hFFF, 0, 0, 0, 0);
    step(1, 1, 8'h96, 0, 0, 12'h000, 0, 0, 0, 0);
    // enable low for 3 edges while controls toggle
    step(1, 0, 8'hEE, 1, 1, 12'h123, 1, 1, 1, 0);
    step(1, 0, 8'h11, 1, 0, 12'h456, 1, 0, 1, 0);
    step(1, 0, 8'h22, 0, 1, 12'h789, 1, 1, 0, 0);
    // mid-EXEC async reset (phase is EXEC here)
    step(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0, 0);
    idle(1);
`ifdef BREAKPOINT_EN
    bp_addr = 12'h005;
    step(1, 1, 8'h10, 0, 1, 12'h005, 0, 0, 0, 0);
    step(1, 1, 8'h3C, 0, 0, 12'h000, 0, 0, 0, 0);
    repeat (10) step(1, 1, 8'h77, 1, 1, 12'h0AA, 1, 1, 1, 0);
    step(1, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0, 1);
    step(1, 1, 8'h00, 0, 1, 12'h005, 1, 1, 1, 1);
    step(1, 1, 8'h88, 0, 0, 12'h000, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 400; i++) begin
      bp_addr = 12'($urandom_range(0, 7));
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), 8'($urandom),
           1'($urandom), 1'($urandom), 12'($urandom_range(0, 9) == 0 ? 4095 : $urandom_range(0, 8)),
           1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    drv_done = 1;
  end

  initial begin : monitor
    exp_t e;
    int cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      cycles++;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare_all("edge", e);
      end else if (drv_done) begin
        break;
      end
      if (cycles > 5000) begin
        check("cycle_budget", cycles, 5000);
        break;
      end
    end
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
